hour_counter_bcd: RTL and testbench

Parametrised successor to the clock's 24-hour hour counter. Keeps the hour as two BCD digits (tens 0-2, units 0-9) and advances on a qualified tick. Adds a tick prescaler, synchronous load for time setting, a runtime 12/24-hour display mode with a PM flag, a day-wrap carry, and an optional decrement for setting. Sits after the minutes counter; its tick is the minutes carry, and its digits feed the 7-segment decoders.

---
 rtl/clock_pkg.sv | 39 +++
 rtl/hour_counter_bcd_12h_map.sv | 42 ++++
 rtl/hour_counter_bcd.sv | 143 ++++++++++++++
 tb/tb_hour_counter_bcd.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD time-keeping definitions for the clock's hour and minute counters.
package clock_pkg;

    localparam int UNITS_W   = 4;
    localparam int TENS_W    = 2;
    localparam int HOURS_MAX = 23;

    typedef logic [UNITS_W-1:0] units_t;
    typedef logic [TENS_W-1:0]  tens_t;

    typedef struct packed {
        tens_t  t;
        units_t u;
    } hour_bcd_t;

    localparam tens_t  HOURS_MAX_TENS  = 2'd2;
    localparam units_t HOURS_MAX_UNITS = 4'd3;
    localparam units_t BCD_MAX_UNITS   = 4'd9;

    // Noon stays 12 in 12 h display; midnight (00) is shown as 12 as well.
    localparam tens_t  NOON_TENS           = 2'd1;
    localparam units_t NOON_UNITS          = 4'd2;
    localparam tens_t  MIDNIGHT_12H_TENS   = 2'd1;
    localparam units_t MIDNIGHT_12H_UNITS  = 4'd2;

    function automatic logic hour_bcd_valid(input tens_t t, input units_t u);
        logic ok;
        ok = (u <= BCD_MAX_UNITS) &&
             ((t < HOURS_MAX_TENS) || ((t == HOURS_MAX_TENS) && (u <= HOURS_MAX_UNITS)));
        return ok;
    endfunction

    function automatic logic hour_is_pm(input tens_t t, input units_t u);
        logic is_pm;
        is_pm = (t > NOON_TENS) || ((t == NOON_TENS) && (u >= NOON_UNITS));
        return is_pm;
    endfunction

endpackage

// File: rtl/hour_counter_bcd_12h_map.sv
// Combinational 24 h -> displayed (12 h or 24 h) BCD mapping plus PM flag.
module hour_12h_map
    import clock_pkg::*;
(
    input  logic [TENS_W-1:0]  h_tens,
    input  logic [UNITS_W-1:0] h_units,
    input  logic               mode_12h,
    output logic [TENS_W-1:0]  disp_tens,
    output logic [UNITS_W-1:0] disp_units,
    output logic               pm
);

    logic is_pm;
    logic is_noon;

    always_comb begin
        is_pm      = hour_is_pm(h_tens, h_units);
        is_noon    = (h_tens == NOON_TENS) && (h_units == NOON_UNITS);
        pm         = is_pm;
        disp_tens  = h_tens;
        disp_units = h_units;
        if (mode_12h) begin
            if ((h_tens == 2'd0) && (h_units == 4'd0)) begin
                disp_tens  = MIDNIGHT_12H_TENS;
                disp_units = MIDNIGHT_12H_UNITS;
            end else if (is_pm && !is_noon) begin
                // BCD subtract of 12, split by which tens/units borrow applies.
                if (h_tens == 2'd1) begin
                    disp_tens  = 2'd0;
                    disp_units = h_units - 4'd2;
                end else if (h_units <= 4'd1) begin
                    disp_tens  = 2'd0;
                    disp_units = h_units + 4'd8;
                end else begin
                    disp_tens  = 2'd1;
                    disp_units = h_units - 4'd2;
                end
            end
        end
    end

endmodule

// File: rtl/hour_counter_bcd.sv
// 24 h BCD hour counter with tick prescaler, load, 12/24 h display and day carry.
// Define HOUR_DEC_EN to enable the dec (hour decrement) input.
module hour_counter_bcd
    import clock_pkg::*;
#(
    parameter int RESET_HOUR = 0,
    parameter int TICK_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       dec,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [3:0] load_digit1,
    input  logic [1:0] load_digit2,
    output logic [3:0] counter_digit1,
    output logic [1:0] counter_digit2,
    output logic       pm,
    output logic       day_carry,
    output logic       load_err
);

    if ((RESET_HOUR < 0) || (RESET_HOUR > HOURS_MAX)) begin : g_bad_reset_hour
        $error("hour_counter_bcd: RESET_HOUR must be 0..23");
    end
    if ((TICK_DIV < 1) || (TICK_DIV > 255)) begin : g_bad_tick_div
        $error("hour_counter_bcd: TICK_DIV must be 1..255");
    end

    localparam tens_t      RST_TENS  = tens_t'(RESET_HOUR / 10);
    localparam units_t     RST_UNITS = units_t'(RESET_HOUR % 10);
    localparam logic [7:0] PRE_LAST  = 8'(TICK_DIV - 1);

    hour_bcd_t  hour_q, hour_d;
    logic [7:0] pre_q, pre_d;
    logic       day_carry_q, day_carry_d;
    logic       load_err_q, load_err_d;
    logic       inc_req;
    logic       at_max;

    function automatic hour_bcd_t hour_inc(input hour_bcd_t h);
        hour_bcd_t r;
        if ((h.t == HOURS_MAX_TENS) && (h.u == HOURS_MAX_UNITS)) begin
            r.t = 2'd0;
            r.u = 4'd0;
        end else if (h.u == BCD_MAX_UNITS) begin
            r.t = h.t + 2'd1;
            r.u = 4'd0;
        end else begin
            r.t = h.t;
            r.u = h.u + 4'd1;
        end
        return r;
    endfunction

`ifdef HOUR_DEC_EN
    logic dec_req;

    function automatic hour_bcd_t hour_dec(input hour_bcd_t h);
        hour_bcd_t r;
        if ((h.t == 2'd0) && (h.u == 4'd0)) begin
            r.t = HOURS_MAX_TENS;
            r.u = HOURS_MAX_UNITS;
        end else if (h.u == 4'd0) begin
            r.t = h.t - 2'd1;
            r.u = BCD_MAX_UNITS;
        end else begin
            r.t = h.t;
            r.u = h.u - 4'd1;
        end
        return r;
    endfunction

    // Simultaneous tick and dec cancel out.
    assign inc_req = tick & ~dec;
    assign dec_req = dec & ~tick;
`else
    logic unused_dec;

    assign inc_req    = tick;
    assign unused_dec = dec;
`endif

    assign at_max = (hour_q.t == HOURS_MAX_TENS) && (hour_q.u == HOURS_MAX_UNITS);

    always_comb begin
        hour_d      = hour_q;
        pre_d       = pre_q;
        day_carry_d = 1'b0;
        load_err_d  = 1'b0;
        if (load) begin
            if (hour_bcd_valid(load_digit2, load_digit1)) begin
                hour_d.t = load_digit2;
                hour_d.u = load_digit1;
                pre_d    = 8'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_req) begin
            if (pre_q == PRE_LAST) begin
                pre_d       = 8'd0;
                hour_d      = hour_inc(hour_q);
                day_carry_d = at_max;
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end
`ifdef HOUR_DEC_EN
        else if (dec_req) begin
            hour_d = hour_dec(hour_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour_q.t    <= RST_TENS;
            hour_q.u    <= RST_UNITS;
            pre_q       <= 8'd0;
            day_carry_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            pre_q       <= pre_d;
            day_carry_q <= day_carry_d;
            load_err_q  <= load_err_d;
        end
    end

    hour_12h_map u_map (
        .h_tens     (hour_q.t),
        .h_units    (hour_q.u),
        .mode_12h   (mode_12h),
        .disp_tens  (counter_digit2),
        .disp_units (counter_digit1),
        .pm         (pm)
    );

    assign day_carry = day_carry_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_hour_counter_bcd.sv
// Directed bench: one counter with TICK_DIV=1 and one with TICK_DIV=60.
module tb_hour_counter_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick1, tick60, dec, mode_12h, load;
    logic [3:0] ld_u;
    logic [1:0] ld_t;

    logic [3:0] d1_u, d60_u;
    logic [1:0] d1_t, d60_t;
    logic       d1_pm, d1_dc, d1_le, d60_pm, d60_dc, d60_le;

    int n_tests = 0;
    int n_fail  = 0;
    int changes;

    always #5 clk = ~clk;

    hour_counter_bcd #(.RESET_HOUR(0), .TICK_DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .tick(tick1), .dec(dec), .mode_12h(mode_12h),
        .load(load), .load_digit1(ld_u), .load_digit2(ld_t),
        .counter_digit1(d1_u), .counter_digit2(d1_t), .pm(d1_pm),
        .day_carry(d1_dc), .load_err(d1_le)
    );

    hour_counter_bcd #(.RESET_HOUR(0), .TICK_DIV(60)) u_d60 (
        .clk(clk), .reset(reset), .tick(tick60), .dec(dec), .mode_12h(mode_12h),
        .load(load), .load_digit1(ld_u), .load_digit2(ld_t),
        .counter_digit1(d60_u), .counter_digit2(d60_t), .pm(d60_pm),
        .day_carry(d60_dc), .load_err(d60_le)
    );

    function automatic logic [7:0] hx1();
        return {2'b00, d1_t, d1_u};
    endfunction

    function automatic logic [7:0] hx60();
        return {2'b00, d60_t, d60_u};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] t, input logic [3:0] u);
        ld_t = t;
        ld_u = u;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic ticks60(input int n);
        tick60 = 1'b1;
        repeat (n) step();
        tick60 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; tick1 = 1'b0; tick60 = 1'b0; dec = 1'b0;
        mode_12h = 1'b0; load = 1'b0; ld_u = 4'd0; ld_t = 2'd0;
        #1;
        check("rst_hour24", hx1(), 8'h00);
        check("rst_pm", {7'd0, d1_pm}, 8'd0);
        check("rst_carry", {7'd0, d1_dc}, 8'd0);
        check("rst_lerr", {7'd0, d1_le}, 8'd0);
        check("rst_hour_d60", hx60(), 8'h00);
        mode_12h = 1'b1;
        #1;
        check("rst_hour12", hx1(), 8'h12);
        mode_12h = 1'b0;

        @(posedge clk);
        #1 reset = 1'b1;
        changes = 0;
        repeat (100) begin
            step();
            if (hx1() != 8'h00 || d1_dc || d1_le) changes++;
        end
        check("hold100", 8'(changes), 8'd0);

        for (int i = 1; i <= 24; i++) begin
            tick1 = 1'b1;
            step();
            tick1 = 1'b0;
            check($sformatf("tick_hour_%0d", i), hx1(),
                  8'((((i % 24) / 10) * 16) + ((i % 24) % 10)));
            check($sformatf("tick_carry_%0d", i), {7'd0, d1_dc}, (i == 24) ? 8'd1 : 8'd0);
            step();
            check($sformatf("gap_carry_%0d", i), {7'd0, d1_dc}, 8'd0);
        end

        ticks60(59);
        check("div60_59", hx60(), 8'h00);
        ticks60(1);
        check("div60_60", hx60(), 8'h01);
        ticks60(30);
        do_load(2'd0, 4'd5);
        check("div60_load05", hx60(), 8'h05);
        ticks60(59);
        check("div60_post_load_59", hx60(), 8'h05);
        ticks60(1);
        check("div60_post_load_60", hx60(), 8'h06);

        mode_12h = 1'b1;
        do_load(2'd1, 4'd3);
        check("m12_13_disp", hx1(), 8'h01);
        check("m12_13_pm", {7'd0, d1_pm}, 8'd1);
        do_load(2'd0, 4'd0);
        check("m12_00_disp", hx1(), 8'h12);
        check("m12_00_pm", {7'd0, d1_pm}, 8'd0);
        do_load(2'd2, 4'd3);
        check("m12_23_disp", hx1(), 8'h11);
        check("m12_23_pm", {7'd0, d1_pm}, 8'd1);
        do_load(2'd1, 4'd2);
        check("m12_12_disp", hx1(), 8'h12);
        check("m12_12_pm", {7'd0, d1_pm}, 8'd1);
        mode_12h = 1'b0;
        #1;
        check("m24_12_disp", hx1(), 8'h12);
        mode_12h = 1'b1;
        #1;
        do_load(2'd2, 4'd1);
        check("m12_21_disp", hx1(), 8'h09);
        do_load(2'd2, 4'd5);
        check("bad25_hour", hx1(), 8'h09);
        check("bad25_lerr", {7'd0, d1_le}, 8'd1);
        step();
        check("bad25_lerr_clr", {7'd0, d1_le}, 8'd0);
        do_load(2'd0, 4'd10);
        check("bad0a_lerr", {7'd0, d1_le}, 8'd1);
        check("bad0a_hour", hx1(), 8'h09);
        do_load(2'd1, 4'd0);
        check("m12_10_disp", hx1(), 8'h10);
        check("m12_10_pm", {7'd0, d1_pm}, 8'd0);
        mode_12h = 1'b0;

        ld_t = 2'd0; ld_u = 4'd7; load = 1'b1; tick1 = 1'b1;
        step();
        load = 1'b0; tick1 = 1'b0;
        check("load_beats_tick", hx1(), 8'h07);

`ifdef HOUR_DEC_EN
        do_load(2'd0, 4'd0);
        dec = 1'b1; step(); dec = 1'b0;
        check("dec_00_hour", hx1(), 8'h23);
        check("dec_00_carry", {7'd0, d1_dc}, 8'd0);
        do_load(2'd1, 4'd0);
        dec = 1'b1; step(); dec = 1'b0;
        check("dec_10_hour", hx1(), 8'h09);
        tick1 = 1'b1; dec = 1'b1; step(); tick1 = 1'b0; dec = 1'b0;
        check("tick_dec_hold", hx1(), 8'h09);
`else
        do_load(2'd0, 4'd5);
        dec = 1'b1; step(); dec = 1'b0;
        check("dec_ignored", hx1(), 8'h05);
        tick1 = 1'b1; dec = 1'b1; step(); tick1 = 1'b0; dec = 1'b0;
        check("tick_with_dec_inc", hx1(), 8'h06);
`endif

        do_load(2'd1, 4'd7);
        ticks60(25);
        check("mid_d60_17", hx60(), 8'h17);
        tick1 = 1'b1;
        repeat (6) step();
        check("mid_d1_23", hx1(), 8'h23);
        step();
        tick1 = 1'b0;
        check("mid_d1_wrap", hx1(), 8'h00);
        check("mid_d1_carry", {7'd0, d1_dc}, 8'd1);
        reset = 1'b0;
        #1;
        check("async_rst_carry", {7'd0, d1_dc}, 8'd0);
        check("async_rst_d60", hx60(), 8'h00);
        check("async_rst_d1", hx1(), 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;
        ticks60(59);
        check("post_rst_59", hx60(), 8'h00);
        ticks60(1);
        check("post_rst_60", hx60(), 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
